// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state encodings and the counter-width helper for alu_seq.
package alu_pkg;

  // 3-bit opcode space.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Ceiling log2; counters are sized clog2(WIDTH+1) so they can hold WIDTH itself.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request and result channels of alu_seq.
// Optional macro ALU_SEQ_OVF_FLAG_EN adds the signed-overflow flag vf.
//
// Handshake rules (both channels): a transfer happens at a rising clk edge
// where valid && ready are both 1. The producer holds its payload stable while
// valid is high; ready may not depend combinationally on valid. in_ready is a
// pure decode of the FSM state, and r/flags stay frozen while out_valid is high
// until out_ready completes the transfer.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             cf;
  logic             sf;
  logic             zf;
`ifdef ALU_SEQ_OVF_FLAG_EN
  logic             vf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, r, cf, sf, zf, vf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, r, cf, sf, zf, vf
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, r, cf, sf, zf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, r, cf, sf, zf
  );
`endif
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per
// cycle for WIDTH cycles after start_i. done_o flags the cycle whose edge
// performs the final step; product_o then carries the completed product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = clog2(WIDTH + 1);

  // acc holds {partial high half, remaining multiplier bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] step;

  // One shift-add step: conditionally add the multiplicand, then shift right.
  always_comb begin
    hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    step   = {hi_sum, acc_q[WIDTH-1:1]};
  end

  // Load on start, otherwise iterate while busy.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i) begin
      acc_d   = {{WIDTH{1'b0}}, b_i};
      mcand_d = a_i;
      cnt_d   = CW'(WIDTH);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign done_o    = busy_q && (cnt_q == CW'(1));
  assign product_o = step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result/flags, bit-serial
// shifts and an iterative multiplier.
// Optional macro ALU_SEQ_OVF_FLAG_EN adds the signed-overflow flag vf.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output alu_state_e state_o
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, op_in;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             cf_q, cf_d;
  logic             sf_q, sf_d;
  logic             zf_q, zf_d;

  logic             accept;
  logic             b_zero;
  logic             b_big;
  logic             shift_multi;
  logic             exec_last;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ld;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign op_in       = alu_op_e'(bus.op);
  assign accept      = bus.in_valid && (state_q == ST_IDLE);
  assign b_zero      = (bus.b == '0);
  assign b_big       = ({1'b0, bus.b} >= WIDTH_V);
  assign shift_multi = ((op_in == OP_SHL) || (op_in == OP_SHR)) && !b_zero && !b_big;
  assign sum         = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff        = {1'b0, bus.a} - {1'b0, bus.b};
  assign exec_last   = (op_q == OP_MUL) ? mul_done : (cnt_q == CW'(1));

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && (op_in == OP_MUL)),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: multi-cycle ops detour through EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ((op_in == OP_MUL) || shift_multi) ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        if (exec_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals are pure state decodes.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    state_o       = state_q;
  end

  // Datapath next state: single-cycle results at accept, shift/mul steps in EXEC.
  always_comb begin
    op_d  = op_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    r_d   = r_q;
    cf_d  = cf_q;
    sf_d  = sf_q;
    zf_d  = zf_q;
    ld    = 1'b0;
    res   = '0;
    c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          sh_d  = bus.a;
          cnt_d = CW'(bus.b);
          ld    = 1'b1;
          case (op_in)
            OP_ADD: begin
              res = sum[WIDTH-1:0];
              c   = sum[WIDTH];
            end
            OP_SUB: begin
              res = diff[WIDTH-1:0];
              c   = diff[WIDTH];
            end
            OP_AND: res = bus.a & bus.b;
            OP_OR:  res = bus.a | bus.b;
            OP_XOR: res = bus.a ^ bus.b;
            OP_SHL, OP_SHR: begin
              if (b_zero) begin
                res = bus.a;
              end else if (b_big) begin
                res = '0;
                c   = (op_in == OP_SHL) ? bus.a[WIDTH-1] : bus.a[0];
              end else begin
                ld = 1'b0;
              end
            end
            default: ld = 1'b0;
          endcase
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          if (mul_done) begin
            ld  = 1'b1;
            res = mul_prod[WIDTH-1:0];
            c   = |mul_prod[2*WIDTH-1:WIDTH];
          end
        end else begin
          if (op_q == OP_SHL) begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
            c    = sh_q[WIDTH-1];
          end else begin
            sh_d = {1'b0, sh_q[WIDTH-1:1]};
            c    = sh_q[0];
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            ld  = 1'b1;
            res = sh_d;
          end
        end
      end
      default: ;
    endcase
    if (ld) begin
      r_d  = res;
      cf_d = c;
      sf_d = res[WIDTH-1];
      zf_d = (res == '0);
    end
  end

  // Datapath registers; result and flags hold until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_ADD;
      sh_q  <= '0;
      cnt_q <= '0;
      r_q   <= '0;
      cf_q  <= 1'b0;
      sf_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      r_q   <= r_d;
      cf_q  <= cf_d;
      sf_q  <= sf_d;
      zf_q  <= zf_d;
    end
  end

  assign bus.r  = r_q;
  assign bus.cf = cf_q;
  assign bus.sf = sf_q;
  assign bus.zf = zf_q;

`ifdef ALU_SEQ_OVF_FLAG_EN
  logic vf_q, vf_d;

  // Signed overflow is only meaningful for ADD/SUB; every other op clears it.
  always_comb begin
    vf_d = vf_q;
    if (accept) begin
      case (op_in)
        OP_ADD:  vf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        OP_SUB:  vf_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
        default: vf_d = 1'b0;
      endcase
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vf_q <= 1'b0;
    end else begin
      vf_q <= vf_d;
    end
  end

  assign bus.vf = vf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, random ops against a reference model,
// backpressure and mid-operation reset sequences for alu_seq (WIDTH=4).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  typedef struct {
    int op;
    int a;
    int b;
    int r;
    int cf;
    int vf;
    int lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  alu_state_e state;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference model from the arithmetic rules (values in 0..15).
  function automatic vec_t model(input int op, input int a, input int b);
    vec_t m;
    int   s;
    m.op = op; m.a = a; m.b = b;
    m.r = 0; m.cf = 0; m.vf = 0; m.lat = 1;
    case (op)
      0: begin
        s = a + b; m.r = s % 16; m.cf = (s > 15) ? 1 : 0;
        s = sx(a) + sx(b); m.vf = (s < -8 || s > 7) ? 1 : 0;
      end
      1: begin
        m.r = (a - b + 16) % 16; m.cf = (a < b) ? 1 : 0;
        s = sx(a) - sx(b); m.vf = (s < -8 || s > 7) ? 1 : 0;
      end
      2: m.r = a & b;
      3: m.r = a | b;
      4: m.r = a ^ b;
      5: begin
        if (b == 0) m.r = a;
        else if (b >= W) begin m.r = 0; m.cf = (a >> (W - 1)) & 1; end
        else begin m.r = (a << b) % 16; m.cf = (a >> (W - b)) & 1; m.lat = b + 1; end
      end
      6: begin
        if (b == 0) m.r = a;
        else if (b >= W) begin m.r = 0; m.cf = a & 1; end
        else begin m.r = a >> b; m.cf = (a >> (b - 1)) & 1; m.lat = b + 1; end
      end
      default: begin
        s = a * b; m.r = s % 16; m.cf = (s > 15) ? 1 : 0; m.lat = W + 1;
      end
    endcase
    return m;
  endfunction

  task automatic chk_outputs(input string name, input vec_t e);
    chk({name, ".r"}, int'(bus.r), e.r);
    chk({name, ".cf"}, int'(bus.cf), e.cf);
    chk({name, ".sf"}, int'(bus.sf), (e.r >= 8) ? 1 : 0);
    chk({name, ".zf"}, int'(bus.zf), (e.r == 0) ? 1 : 0);
`ifdef ALU_SEQ_OVF_FLAG_EN
    chk({name, ".vf"}, int'(bus.vf), e.vf);
`endif
  endtask

  // Driver: present one op, scramble inputs after accept, measure latency,
  // hold backpressure (optionally with a competing in_valid), then release.
  task automatic run_op(input string name, input vec_t e, input int hold, input bit iv_hold);
    int lat;
    chk({name, ".in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.op = 3'(e.op);
    bus.a  = 4'(e.a);
    bus.b  = 4'(e.b);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat = lat + 1;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        bus.a  = 4'($urandom_range(0, 15));
        bus.b  = 4'($urandom_range(0, 15));
        bus.op = 3'($urandom_range(0, 7));
      end
    end while (!bus.out_valid && lat < 64);
    chk({name, ".out_valid"}, int'(bus.out_valid), 1);
    chk({name, ".latency"}, lat, e.lat);
    chk_outputs(name, e);
    bus.in_valid = iv_hold;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_outputs({name, ".hold"}, e);
      chk({name, ".hold.out_valid"}, int'(bus.out_valid), 1);
      chk({name, ".hold.in_ready"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({name, ".rel.out_valid"}, int'(bus.out_valid), 0);
    chk({name, ".rel.in_ready"}, int'(bus.in_ready), 1);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t e;
    int   op, a, b;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk); #1;
    chk("rst.in_ready", int'(bus.in_ready), 1);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.r", int'(bus.r), 0);
    chk("rst.flags", int'({bus.cf, bus.sf, bus.zf}), 0);
    chk("rst.state", int'(state), int'(ST_IDLE));
`ifdef ALU_SEQ_OVF_FLAG_EN
    chk("rst.vf", int'(bus.vf), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table {op, a, b, r, cf, vf, latency}.
    vecs.push_back('{0,  3,  3,  6, 0, 0, 1});
    vecs.push_back('{0, 15,  1,  0, 1, 0, 1});
    vecs.push_back('{1,  2,  4, 14, 1, 0, 1});
    vecs.push_back('{0,  7,  1,  8, 0, 1, 1});
    vecs.push_back('{1,  8,  1,  7, 0, 1, 1});
    vecs.push_back('{2, 12, 10,  8, 0, 0, 1});
    vecs.push_back('{3, 12, 10, 14, 0, 0, 1});
    vecs.push_back('{4, 12, 10,  6, 0, 0, 1});
    vecs.push_back('{5,  3,  2, 12, 0, 0, 3});
    vecs.push_back('{6,  3,  1,  1, 1, 0, 2});
    vecs.push_back('{5,  9,  4,  0, 1, 0, 1});
    vecs.push_back('{5,  1,  3,  8, 0, 0, 4});
    vecs.push_back('{6, 14,  3,  1, 1, 0, 4});
    vecs.push_back('{6,  8,  0,  8, 0, 0, 1});
    vecs.push_back('{6,  9,  7,  0, 1, 0, 1});
    vecs.push_back('{7,  5,  3, 15, 0, 0, 5});
    vecs.push_back('{7,  4,  4,  0, 1, 0, 5});
    vecs.push_back('{7, 15, 15,  1, 1, 0, 5});
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], i % 3, 1'b0);
    end

    // Backpressure for 6 cycles with a competing request pending.
    e = '{0, 5, 6, 11, 0, 1, 1};
    run_op("bp", e, 6, 1'b1);
    @(posedge clk); #1;
    chk("bp.idle_after", int'(bus.out_valid), 0);

    // Random ops against the model, b biased to cover shift boundaries.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 15);
      b  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 15);
      e  = model(op, a, b);
      run_op($sformatf("rnd%0d.op%0d.a%0d.b%0d", i, op, a, b), e, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset two cycles into a MUL.
    bus.in_valid = 1'b1; bus.op = 3'd7; bus.a = 4'd5; bus.b = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mrst.in_exec", int'(state), int'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", int'(bus.out_valid), 0);
    chk("mrst.r", int'(bus.r), 0);
    chk("mrst.flags", int'({bus.cf, bus.sf, bus.zf}), 0);
    chk("mrst.in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mrst.discarded", int'(bus.out_valid), 0);
    end
    e = '{0, 1, 1, 2, 0, 0, 1};
    run_op("mrst.add", e, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
